// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Holds the FSM state and owner encodings plus default widths.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arbOwner_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_DSTREAK = 4;

  // Bits needed to hold a streak count of 0..maxStreak.
  function automatic int streakWidth(input int maxStreak);
    int w;
    w = $clog2(maxStreak + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection for the shared memory port.
// Data requests win by default; after MAX_DSTREAK consecutive data grants
// made while a fetch was waiting, the fetch is given the next grant.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ifReq,
  input  logic      dReq,
  input  logic      grant,
  output arbOwner_t winner
);

  localparam int SW = streakWidth(MAX_DSTREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streakReg;
  logic [SW-1:0] streakNext;
  logic          streakFull;

  assign streakFull = (streakReg == STREAK_MAX);

  // Pick the winner: data unless a waiting fetch has been passed over too often.
  always_comb begin
    winner = OWN_IF;
    if (dReq && !(ifReq && streakFull)) begin
      winner = OWN_D;
    end
  end

  // Streak bookkeeping, only moves on an actual grant.
  always_comb begin
    streakNext = streakReg;
    if (grant) begin
      if (winner == OWN_D) begin
        if (!ifReq) begin
          streakNext = '0;
        end else if (!streakFull) begin
          streakNext = streakReg + 1'b1;
        end
      end else begin
        streakNext = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streakReg <= '0;
    end else begin
      streakReg <= streakNext;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage and the load/store
// stage. One transaction outstanding at a time: issue in IDLE, wait for the
// memory response, then pulse the owner's ack for one cycle in RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                stall_if_o,
  output logic                stall_mem_o
);

  arbState_t         stateReg;
  arbState_t         stateNext;
  arbOwner_t         ownerReg;
  arbOwner_t         ownerNext;
  logic              weReg;
  logic              weNext;
  logic              ifAckReg;
  logic              dAckReg;
  logic [DATA_W-1:0] ifRdataReg;
  logic [DATA_W-1:0] dRdataReg;

  logic              anyReq;
  logic              issue;
  logic              respTaken;
  arbOwner_t         winner;

  assign anyReq = if_req_i | d_req_i;

  // A response counts only while a transaction is outstanding; anything
  // arriving in IDLE or RESP (e.g. left over from before a reset) is dropped.
  assign respTaken = (stateReg == WAIT) && mem_rvalid_i;

  mem_arb_grant #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) uGrant (
    .clk    (clk),
    .rst    (rst),
    .ifReq  (if_req_i),
    .dReq   (d_req_i),
    .grant  (issue),
    .winner (winner)
  );

  // Next-state logic: issue from IDLE, wait for the response, one ack cycle.
  always_comb begin
    stateNext = stateReg;
    ownerNext = ownerReg;
    weNext    = weReg;
    issue     = 1'b0;
    case (stateReg)
      IDLE: begin
        // Nothing is issued while reset is held, even though IDLE is combinational.
        if (anyReq && !rst) begin
          issue     = 1'b1;
          ownerNext = winner;
          weNext    = (winner == OWN_D) && d_we_i;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Memory request fields: the winner's fields during the issue cycle, zero otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (issue) begin
      mem_req_o = 1'b1;
      if (winner == OWN_D) begin
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_be_o    = d_be_i;
      end else begin
        mem_addr_o  = if_addr_i;
      end
    end
  end

  // FSM state, owner and direction of the outstanding transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      ownerReg <= OWN_IF;
      weReg    <= 1'b0;
    end else begin
      stateReg <= stateNext;
      ownerReg <= ownerNext;
      weReg    <= weNext;
    end
  end

  // Response capture: the ack is high exactly during RESP; stores keep the old load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifAckReg   <= 1'b0;
      dAckReg    <= 1'b0;
      ifRdataReg <= '0;
      dRdataReg  <= '0;
    end else begin
      ifAckReg <= 1'b0;
      dAckReg  <= 1'b0;
      if (respTaken) begin
        if (ownerReg == OWN_IF) begin
          ifAckReg   <= 1'b1;
          ifRdataReg <= mem_rdata_i;
        end else begin
          dAckReg <= 1'b1;
          if (!weReg) begin
            dRdataReg <= mem_rdata_i;
          end
        end
      end
    end
  end

  assign if_ack_o   = ifAckReg;
  assign d_ack_o    = dAckReg;
  assign if_rdata_o = ifRdataReg;
  assign d_rdata_o  = dRdataReg;

  // Stalls hold the requesting stage until its ack cycle.
  assign stall_if_o  = if_req_i & ~ifAckReg;
  assign stall_mem_o = d_req_i & ~dAckReg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined core: shares one unified instruction/data memory port between the IF stage (fetch) and the MEM stage (load/store). Grants one outstanding transaction at a time, returns read data with a one-cycle acknowledge pulse, and drives per-stage stall outputs that the hazard logic ORs into PC/IF-ID/ID-EX enables. Data-side requests have priority, with a bounded-streak rule that prevents fetch starvation.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- MAX_DSTREAK, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request, level, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, valid while if_ack_o=1
- if_ack_o  out  1  one-cycle completion pulse for fetch
- d_req_i  in  1  data request, level, held until d_ack_o
- d_we_i  in  1  1=store, 0=load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_be_i  in  DATA_W/8  store byte enables
- d_rdata_o  out  DATA_W  load data, valid while d_ack_o=1
- d_ack_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  issue strobe, one cycle per transaction
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/ADDR_W/DATA_W/DATA_W/8  request fields, valid with mem_req_o
- mem_rvalid_i  in  1  memory response (reads and writes), ≥1 cycle after issue
- mem_rdata_i  in  DATA_W  read data, valid with mem_rvalid_i
- stall_if_o  out  1  if_req_i & ~if_ack_o
- stall_mem_o  out  1  d_req_i & ~d_ack_o

## Operation
- FSM states: IDLE, WAIT, RESP. Owner register: OWN_IF / OWN_D.
- IDLE: if any request is pending, grant one, assert mem_req_o combinationally with the winner's fields (fetch: we=0, be=0, wdata=0), latch the owner, go to WAIT. Otherwise mem_req_o=0, stay.
- Grant rule: only one request pending → it wins. Both pending → data wins unless streak==MAX_DSTREAK, in which case fetch wins.
- Streak counter (0..MAX_DSTREAK, saturating): on a data grant with if_req_i=1 → +1; on a data grant with if_req_i=0 → 0; on a fetch grant → 0.
- WAIT: mem_req_o=0; on mem_rvalid_i, register mem_rdata_i into the owner's rdata (loads/fetches only; stores leave rdata unchanged), go to RESP.
- RESP: the owner's ack is high for exactly this cycle; no issue occurs; next state is IDLE. Requesters sample ack on this edge and may drop or change req from the following cycle.
- mem_rvalid_i in IDLE or RESP is ignored (covers responses still in flight across reset).
- Stall outputs are combinational from the req inputs and the registered ack.

## Timing
- Issue at cycle T, mem_rvalid_i at T+L (L≥1), ack at T+L+1, earliest next issue at T+L+2. Throughput is one transaction per L+2 cycles.
- Registered outputs: if_ack_o, d_ack_o, if_rdata_o, d_rdata_o. mem_* outputs are combinational in IDLE.
- Reset (async, any state): state=IDLE, owner=OWN_IF, streak=0, both acks=0, both rdata=0, mem_req_o=0. An in-flight transaction is abandoned, and its late response is dropped.
- A request deasserted while in WAIT still completes (ack pulses); the requester ignores it.

## Structure
- Package mem_arb_pkg: state enum (IDLE/WAIT/RESP), owner enum (OWN_IF/OWN_D), default widths.
- Sub-module mem_arb_grant: streak counter plus winner selection (inputs: reqs, grant strobe; output: winner). The FSM, response capture and stall logic stay in mem_arbiter.

## Test plan
- Fetch only, addr 0x0000_0010, L=1 → mem_req_o 1 cycle with addr 0x10, we=0; if_ack_o pulses at T+2 with if_rdata_o=mem data 0x0010_0093; stall_if_o high T..T+1.
- Simultaneous fetch 0x20 and load 0x100, L=2 → data issued first, d_ack_o at T+3; fetch issued at T+4, if_ack_o at T+7.
- Store d_we=1, be=4'b0001, wdata=0xAB, addr 0x1F0 → mem fields match; d_ack_o pulses; d_rdata_o keeps its previous value.
- Fetch held high with 6 back-to-back loads, MAX_DSTREAK=4 → grant order D,D,D,D,IF,D,D.
- rst asserted in WAIT, then mem_rvalid_i arrives after release → no ack, all outputs at reset values, next request issued normally.
- Spurious mem_rvalid_i in IDLE with no requests → no ack, state stays IDLE.
